// File: rtl/phase_sequencer.sv
// phase_sequencer: instruction-phase sequencer and control decoder for the
// VeriRISC CPU. Owns the 3-bit phase register and the halted flag, and decodes
// every datapath control strobe from phase, opcode and the zero flag.
//
// Optional feature macro: PHASE_SEQ_RESUME_EN
//   When defined, a `resume` input releases the halted state and continues
//   execution at phase 5 of the HLT instruction. When undefined, halted is
//   terminal until rst.
module phase_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef PHASE_SEQ_RESUME_EN
    input  logic       resume,
`endif
    output logic [2:0] phase,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PHASE_FETCH_END = 3'd4;
    localparam logic [2:0] PHASE_RESUME    = 3'd5;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

    mode_t      mode_q, mode_d;
    logic [2:0] phase_q, phase_d;
    logic       aluOp;

    assign aluOp = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // State register: synchronous reset to phase 0, running.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 3'd0;
            mode_q  <= MODE_RUN;
        end else begin
            phase_q <= phase_d;
            mode_q  <= mode_d;
        end
    end

    // Next state: advance the phase while running; HLT in phase 4 freezes the
    // phase at 4 and enters halt instead of advancing.
    always_comb begin
        phase_d = phase_q;
        mode_d  = mode_q;
        if (mode_q == MODE_RUN) begin
            if (enable) begin
                if ((phase_q == PHASE_FETCH_END) && (opcode == OP_HLT)) begin
                    mode_d = MODE_HALT;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
        end
`ifdef PHASE_SEQ_RESUME_EN
        else if (resume && enable) begin
            mode_d  = MODE_RUN;
            phase_d = PHASE_RESUME;
        end
`endif
    end

    // Output decode: levels follow the phase even when stalled; strobes are
    // additionally gated by enable; everything but halt is silenced when halted.
    always_comb begin
        phase  = phase_q;
        halt   = (mode_q == MODE_HALT);
        sel    = 1'b0;
        rd     = 1'b0;
        data_e = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (mode_q == MODE_RUN) begin
            sel    = (phase_q <= 3'd3);
            rd     = ((phase_q >= 3'd1) && (phase_q <= 3'd3)) ||
                     ((phase_q >= 3'd5) && aluOp);
            data_e = (phase_q >= 3'd6) && (opcode == OP_STO);
            if (enable) begin
                ld_ir  = (phase_q == 3'd2) || (phase_q == 3'd3);
                inc_pc = (phase_q == PHASE_FETCH_END) ||
                         ((phase_q == 3'd6) && (opcode == OP_SKZ) && zero);
                ld_pc  = (phase_q >= 3'd6) && (opcode == OP_JMP);
                ld_ac  = (phase_q == 3'd7) && aluOp;
                wr     = (phase_q == 3'd7) && (opcode == OP_STO);
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed-vector bench for phase_sequencer.
// Observed outputs are packed as
//   {halt, phase[2:0], sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}
// and compared against hand-computed constants.
module tb_phase_sequencer;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] opcode;
    logic       zero;
`ifdef PHASE_SEQ_RESUME_EN
    logic       resume;
`endif
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [11:0] observed;

    int vectorCount = 0;
    int failCount   = 0;

    // Common fetch half (phases 0-3) shared by every opcode, followed by the
    // opcode-specific execute half (phases 4-7).
    logic [11:0] expAdd    [8] = '{12'b0_000_1000_0000, 12'b0_001_1100_0000,
                                   12'b0_010_1110_0000, 12'b0_011_1110_0000,
                                   12'b0_100_0001_0000, 12'b0_101_0100_0000,
                                   12'b0_110_0100_0000, 12'b0_111_0100_0100};
    logic [11:0] expSkzZ1  [8] = '{12'b0_000_1000_0000, 12'b0_001_1100_0000,
                                   12'b0_010_1110_0000, 12'b0_011_1110_0000,
                                   12'b0_100_0001_0000, 12'b0_101_0000_0000,
                                   12'b0_110_0001_0000, 12'b0_111_0000_0000};
    logic [11:0] expSkzZ0  [8] = '{12'b0_000_1000_0000, 12'b0_001_1100_0000,
                                   12'b0_010_1110_0000, 12'b0_011_1110_0000,
                                   12'b0_100_0001_0000, 12'b0_101_0000_0000,
                                   12'b0_110_0000_0000, 12'b0_111_0000_0000};
    logic [11:0] expSto    [8] = '{12'b0_000_1000_0000, 12'b0_001_1100_0000,
                                   12'b0_010_1110_0000, 12'b0_011_1110_0000,
                                   12'b0_100_0001_0000, 12'b0_101_0000_0000,
                                   12'b0_110_0000_0001, 12'b0_111_0000_0011};
    logic [11:0] expJmp    [8] = '{12'b0_000_1000_0000, 12'b0_001_1100_0000,
                                   12'b0_010_1110_0000, 12'b0_011_1110_0000,
                                   12'b0_100_0001_0000, 12'b0_101_0000_0000,
                                   12'b0_110_0000_1000, 12'b0_111_0000_1000};

    localparam logic [11:0] EXP_RESET   = 12'b0_000_1000_0000;
    localparam logic [11:0] EXP_STALL4  = 12'b0_100_0000_0000;
    localparam logic [11:0] EXP_HLT4    = 12'b0_100_0001_0000;
    localparam logic [11:0] EXP_HALTED  = 12'b1_100_0000_0000;
    localparam logic [11:0] EXP_HALTP5  = 12'b0_101_0000_0000;

    phase_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .opcode (opcode),
        .zero   (zero),
`ifdef PHASE_SEQ_RESUME_EN
        .resume (resume),
`endif
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    assign observed = {halt, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic en, input logic [2:0] op, input logic z);
        enable = en;
        opcode = op;
        zero   = z;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic runInstr(input logic [2:0] op, input logic z, input string tag,
                            input logic [11:0] exp0, input logic [11:0] exp1,
                            input logic [11:0] exp2, input logic [11:0] exp3,
                            input logic [11:0] exp4, input logic [11:0] exp5,
                            input logic [11:0] exp6, input logic [11:0] exp7);
        logic [11:0] expv [8];
        expv = '{exp0, exp1, exp2, exp3, exp4, exp5, exp6, exp7};
        for (int p = 0; p < 8; p++) begin
            applyStimulus(1'b1, op, z);
            checkOutput($sformatf("%s_p%0d", tag, p), expv[p]);
            tick();
        end
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        opcode = OP_ADD;
        zero   = 1'b0;
`ifdef PHASE_SEQ_RESUME_EN
        resume = 1'b0;
`endif
        #2;

        // Reset state, also with enable held high during reset.
        enable = 1'b1;
        doReset();
        applyStimulus(1'b0, OP_ADD, 1'b0);
        checkOutput("reset", EXP_RESET);

        // ADD instruction, then wrap back to phase 0.
        runInstr(OP_ADD, 1'b0, "add", expAdd[0], expAdd[1], expAdd[2], expAdd[3],
                 expAdd[4], expAdd[5], expAdd[6], expAdd[7]);
        applyStimulus(1'b0, OP_ADD, 1'b0);
        checkOutput("add_wrap", EXP_RESET);

        // SKZ with zero set, then with zero clear.
        runInstr(OP_SKZ, 1'b1, "skz_z1", expSkzZ1[0], expSkzZ1[1], expSkzZ1[2], expSkzZ1[3],
                 expSkzZ1[4], expSkzZ1[5], expSkzZ1[6], expSkzZ1[7]);
        runInstr(OP_SKZ, 1'b0, "skz_z0", expSkzZ0[0], expSkzZ0[1], expSkzZ0[2], expSkzZ0[3],
                 expSkzZ0[4], expSkzZ0[5], expSkzZ0[6], expSkzZ0[7]);

        // STO and JMP.
        runInstr(OP_STO, 1'b0, "sto", expSto[0], expSto[1], expSto[2], expSto[3],
                 expSto[4], expSto[5], expSto[6], expSto[7]);
        runInstr(OP_JMP, 1'b0, "jmp", expJmp[0], expJmp[1], expJmp[2], expJmp[3],
                 expJmp[4], expJmp[5], expJmp[6], expJmp[7]);

        // Stall for 3 cycles in phase 4 of an ADD: no inc_pc until resumed.
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, OP_ADD, 1'b0);
            checkOutput($sformatf("stall_pre_p%0d", p), expAdd[p]);
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, OP_ADD, 1'b0);
            checkOutput($sformatf("stall_s%0d", s), EXP_STALL4);
            tick();
        end
        for (int p = 4; p < 8; p++) begin
            applyStimulus(1'b1, OP_ADD, 1'b0);
            checkOutput($sformatf("stall_post_p%0d", p), expAdd[p]);
            tick();
        end
        applyStimulus(1'b1, OP_ADD, 1'b0);
        checkOutput("stall_wrap", EXP_RESET);

        // HLT: fetch, one inc_pc in phase 4, then halted with phase frozen at 4.
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, OP_HLT, 1'b0);
            checkOutput($sformatf("hlt_p%0d", p), expAdd[p]);
            tick();
        end
        applyStimulus(1'b1, OP_HLT, 1'b0);
        checkOutput("hlt_p4", EXP_HLT4);
        tick();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, OP_HLT, 1'b1);
            checkOutput($sformatf("halted_c%0d", c), EXP_HALTED);
            tick();
        end

`ifdef PHASE_SEQ_RESUME_EN
        // Resume continues at phase 5 of the HLT instruction.
        resume = 1'b1;
        applyStimulus(1'b1, OP_HLT, 1'b0);
        tick();
        resume = 1'b0;
        checkOutput("resume_p5", EXP_HALTP5);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, OP_ADD, 1'b0);
        checkOutput("resume_wrap", EXP_RESET);
        // Halt again so the reset exit is also covered.
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, OP_HLT, 1'b0);
            tick();
        end
        applyStimulus(1'b1, OP_HLT, 1'b0);
        tick();
        checkOutput("rehalted", EXP_HALTED);
`endif

        // Reset out of halt.
        doReset();
        applyStimulus(1'b1, OP_ADD, 1'b0);
        checkOutput("halt_reset", EXP_RESET);

        // Reset in phase 6 of a JMP: next cycle back to phase 0, no ld_pc.
        for (int p = 0; p < 6; p++) begin
            applyStimulus(1'b1, OP_JMP, 1'b0);
            tick();
        end
        applyStimulus(1'b1, OP_JMP, 1'b0);
        checkOutput("jmp_rst_p6", expJmp[6]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("jmp_rst_after", EXP_RESET);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
